// File: rtl/alu_writeback_pkg.sv
// Shared ALU opcode constants and writeback FSM encodings.
// Opcode values 4'hD..4'hF are undefined and are dropped by the writeback stage.
package alu_writeback_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_CMP  = 4'h2;
   localparam logic [3:0] OP_CMPR = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_NOT  = 4'h7;
   localparam logic [3:0] OP_LSH  = 4'h8;
   localparam logic [3:0] OP_RSH  = 4'h9;
   localparam logic [3:0] OP_ARSH = 4'hA;
   localparam logic [3:0] OP_MUL  = 4'hB;
   localparam logic [3:0] OP_FMUL = 4'hC;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR_C = 2'd1,
      ST_WR_D = 2'd2
   } wb_state_t;

   function automatic logic op_defined(input logic [3:0] op);
      return (op <= OP_FMUL);
   endfunction

   // Compares only update flags; they never touch the register file.
   function automatic logic op_no_write(input logic [3:0] op);
      return (op == OP_CMP) || (op == OP_CMPR);
   endfunction

endpackage

// File: rtl/alu_writeback_psr_reg.sv
// Three-bit processor status register (low, negative, zero) with load enable.
// Bit order is {low, negative, zero}.
module alu_writeback_psr_reg (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_load,
   input  logic [2:0] i_flags,
   output logic [2:0] o_flags
);

   logic [2:0] r_flags;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_flags <= 3'b000;
      end else if (i_load) begin
         r_flags <= i_flags;
      end
   end

   assign o_flags = r_flags;

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage after the ALU: commits flags to the PSR and results to the register file,
// splitting MUL into a high-word write to dest and a low-word write to dest+1.
//
// Handshake: a result transfers on any rising edge where in_valid && in_ready; in_ready
// never depends on in_valid, and rf_we is held with stable address/data until rf_busy is low.
module alu_writeback
   import alu_writeback_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            opcode,
   input  logic [REG_ADDR_W-1:0] dest,
   input  logic [DATA_W-1:0]     c,
   input  logic [DATA_W-1:0]     d,
   input  logic                  low,
   input  logic                  negative,
   input  logic                  zero,
   input  logic                  rf_busy,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata,
   output logic                  psr_low,
   output logic                  psr_negative,
   output logic                  psr_zero,
   output logic [1:0]            dbg_state
);

   wb_state_t             r_state;
   wb_state_t             w_next_state;
   logic [3:0]            r_opcode;
   logic [REG_ADDR_W-1:0] r_dest;
   logic [DATA_W-1:0]     r_c;
   logic [DATA_W-1:0]     r_d;

   logic                  w_final_wr;
   logic                  w_accept;
   logic                  w_psr_load;
   logic [2:0]            w_psr_q;
   logic [REG_ADDR_W-1:0] w_dest_inc;

   // The last write of a result frees the stage for a new one on the same edge.
   assign w_final_wr = (r_state == ST_WR_D) ||
                       ((r_state == ST_WR_C) && (r_opcode != OP_MUL));
   assign in_ready   = (r_state == ST_IDLE) || (w_final_wr && !rf_busy);
   assign w_accept   = in_valid && in_ready;
   assign w_psr_load = w_accept && op_defined(opcode);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_opcode <= '0;
         r_dest   <= '0;
         r_c      <= '0;
         r_d      <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_opcode <= opcode;
            r_dest   <= dest;
            r_c      <= c;
            r_d      <= d;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (w_accept) begin
         if (!op_defined(opcode) || op_no_write(opcode)) begin
            w_next_state = ST_IDLE;
         end else begin
            w_next_state = ST_WR_C;
         end
      end else begin
         case (r_state)
            ST_WR_C: begin
               if (!rf_busy) begin
                  w_next_state = (r_opcode == OP_MUL) ? ST_WR_D : ST_IDLE;
               end
            end
            ST_WR_D: begin
               if (!rf_busy) begin
                  w_next_state = ST_IDLE;
               end
            end
            default: w_next_state = r_state;
         endcase
      end
   end

   // Register index arithmetic wraps, so dest 15 puts the MUL low word in register 0.
   assign w_dest_inc = r_dest + {{(REG_ADDR_W-1){1'b0}}, 1'b1};

   assign rf_we    = (r_state != ST_IDLE);
   assign rf_waddr = (r_state == ST_WR_D) ? w_dest_inc : r_dest;
   assign rf_wdata = (r_state == ST_WR_D) ? r_d : r_c;

   alu_writeback_psr_reg u_psr (
      .i_clk   (clk),
      .i_reset (reset),
      .i_load  (w_psr_load),
      .i_flags ({low, negative, zero}),
      .o_flags (w_psr_q)
   );

   assign psr_low      = w_psr_q[2];
   assign psr_negative = w_psr_q[1];
   assign psr_zero     = w_psr_q[0];
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: hand-computed vectors plus a write scoreboard.
module tb_alu_writeback;
   import alu_writeback_pkg::*;

   localparam int DATA_W = 16;
   localparam int AW     = 4;
   localparam int W      = AW + DATA_W;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [3:0]        opcode = '0;
   logic [AW-1:0]     dest = '0;
   logic [DATA_W-1:0] c = '0;
   logic [DATA_W-1:0] d = '0;
   logic              low = 1'b0, negative = 1'b0, zero = 1'b0;
   logic              rf_busy = 1'b0;
   logic              rf_we;
   logic [AW-1:0]     rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              psr_low, psr_negative, psr_zero;
   logic [1:0]        dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_q[$];

   alu_writeback #(.DATA_W(DATA_W), .REG_ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .dest(dest), .c(c), .d(d),
      .low(low), .negative(negative), .zero(zero),
      .rf_busy(rf_busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .psr_low(psr_low), .psr_negative(psr_negative), .psr_zero(psr_zero),
      .dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [AW-1:0] ds,
                        input logic [DATA_W-1:0] cv, input logic [DATA_W-1:0] dv,
                        input logic l, input logic n, input logic z);
      in_valid = 1'b1;
      opcode   = op;
      dest     = ds;
      c        = cv;
      d        = dv;
      low      = l;
      negative = n;
      zero     = z;
   endtask

   task automatic chk_wr(input string tag, input logic [AW-1:0] a, input logic [DATA_W-1:0] v);
      check({tag, "_we"}, rf_we, 1'b1);
      check({tag, "_waddr"}, rf_waddr, a);
      check({tag, "_wdata"}, rf_wdata, v);
   endtask

   task automatic chk_psr(input string tag, input logic [2:0] f);
      check({tag, "_psr"}, {psr_low, psr_negative, psr_zero}, f);
   endtask

   // scoreboard: every completed register-file write must match the next expected one
   always @(negedge clk) begin
      if (!reset && rf_we === 1'b1 && rf_busy === 1'b0) begin
         check("sb_write_expected", exp_q.size() > 0, 1'b1);
         if (exp_q.size() > 0) begin
            check("sb_write", {rf_waddr, rf_wdata}, exp_q.pop_front());
         end
      end
   end

   initial begin
      // reset and idle
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("idle_we", rf_we, 1'b0);
         check("idle_ready", in_ready, 1'b1);
         chk_psr("idle", 3'b000);
         if (i == 0) begin
            check("reset_waddr", rf_waddr, 0);
            check("reset_wdata", rf_wdata, 0);
            check("reset_state", dbg_state, ST_IDLE);
         end
         step();
      end

      // single ADD
      drive(OP_ADD, 4'd3, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
      exp_q.push_back({4'd3, 16'h1234});
      check("add_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      chk_wr("add", 4'd3, 16'h1234);
      check("add_state", dbg_state, ST_WR_C);
      step();
      check("add_after_we", rf_we, 1'b0);
      check("add_after_ready", in_ready, 1'b1);

      // MUL to r15 with two stall cycles in WR_C, low word wraps to r0
      drive(OP_MUL, 4'd15, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0);
      exp_q.push_back({4'd15, 16'h0001});
      exp_q.push_back({4'd0, 16'h8000});
      step();
      in_valid = 1'b0;
      rf_busy  = 1'b1;
      chk_wr("mul_c0", 4'd15, 16'h0001);
      check("mul_c0_ready", in_ready, 1'b0);
      chk_psr("mul", 3'b100);
      step();
      chk_wr("mul_c1", 4'd15, 16'h0001);
      check("mul_c1_ready", in_ready, 1'b0);
      step();
      rf_busy = 1'b0;
      chk_wr("mul_c2", 4'd15, 16'h0001);
      check("mul_c2_ready", in_ready, 1'b0);
      step();
      chk_wr("mul_d", 4'd0, 16'h8000);
      check("mul_d_ready", in_ready, 1'b1);
      check("mul_d_state", dbg_state, ST_WR_D);
      step();
      check("mul_done_we", rf_we, 1'b0);

      // CMP updates flags only, SUB follows immediately
      drive(OP_CMP, 4'd6, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
      step();
      check("cmp_we", rf_we, 1'b0);
      chk_psr("cmp", 3'b011);
      check("cmp_state", dbg_state, ST_IDLE);
      drive(OP_SUB, 4'd5, 16'h00FF, 16'h0000, 1'b0, 1'b0, 1'b0);
      exp_q.push_back({4'd5, 16'h00FF});
      check("sub_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      chk_wr("sub", 4'd5, 16'h00FF);
      chk_psr("sub", 3'b000);
      step();

      // back-to-back stream XOR r1, OR r2, NOT r4
      drive(OP_XOR, 4'd1, 16'hAAAA, 16'h0000, 1'b0, 1'b1, 1'b0);
      exp_q.push_back({4'd1, 16'hAAAA});
      exp_q.push_back({4'd2, 16'h5555});
      exp_q.push_back({4'd4, 16'h0000});
      step();
      drive(OP_OR, 4'd2, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk_wr("xor", 4'd1, 16'hAAAA);
      chk_psr("xor", 3'b010);
      check("xor_ready", in_ready, 1'b1);
      step();
      drive(OP_NOT, 4'd4, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk_wr("or", 4'd2, 16'h5555);
      chk_psr("or", 3'b000);
      step();
      in_valid = 1'b0;
      chk_wr("not", 4'd4, 16'h0000);
      chk_psr("not", 3'b001);
      step();
      check("stream_done_we", rf_we, 1'b0);

      // MUL then ADD accepted on the MUL's final write
      drive(OP_MUL, 4'd2, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
      exp_q.push_back({4'd2, 16'h1111});
      exp_q.push_back({4'd3, 16'h2222});
      exp_q.push_back({4'd10, 16'hABCD});
      step();
      drive(OP_ADD, 4'd10, 16'hABCD, 16'h0000, 1'b1, 1'b1, 1'b0);
      chk_wr("mul2_c", 4'd2, 16'h1111);
      check("mul2_c_ready", in_ready, 1'b0);
      step();
      chk_wr("mul2_d", 4'd3, 16'h2222);
      check("mul2_d_ready", in_ready, 1'b1);
      chk_psr("mul2_d", 3'b000);
      step();
      in_valid = 1'b0;
      chk_wr("add2", 4'd10, 16'hABCD);
      chk_psr("add2", 3'b110);
      step();

      // reset while a write is pending
      drive(OP_AND, 4'd7, 16'h0F0F, 16'h0000, 1'b1, 1'b1, 1'b1);
      step();
      in_valid = 1'b0;
      rf_busy  = 1'b1;
      chk_wr("and_pending", 4'd7, 16'h0F0F);
      chk_psr("and_pending", 3'b111);
      reset = 1'b1;
      step();
      reset   = 1'b0;
      rf_busy = 1'b0;
      check("rst_mid_we", rf_we, 1'b0);
      chk_psr("rst_mid", 3'b000);
      check("rst_mid_state", dbg_state, ST_IDLE);
      check("rst_mid_ready", in_ready, 1'b1);
      step();

      // undefined opcode is consumed without a write and leaves the PSR alone
      drive(OP_LSH, 4'd9, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b1);
      exp_q.push_back({4'd9, 16'h0002});
      step();
      drive(4'hF, 4'd6, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0);
      chk_wr("lsh", 4'd9, 16'h0002);
      chk_psr("lsh", 3'b101);
      check("undef_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      check("undef_we", rf_we, 1'b0);
      chk_psr("undef", 3'b101);
      check("undef_state", dbg_state, ST_IDLE);
      step();
      check("undef_after_we", rf_we, 1'b0);

      step();
      check("sb_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
